// File: rtl/acc_write_arbiter_if.sv
// Write-port bus for the accumulator file arbiter.
// It carries the two requester handshakes and the registered write port to the file.
interface acc_write_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_reg;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              isWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              bad_addr;

    modport master (
        output alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
        input  alu_ready, ld_ready, isWrite, writeReg, writeData, bad_addr
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
        output alu_ready, ld_ready, isWrite, writeReg, writeData, bad_addr
    );
endinterface

// File: rtl/acc_write_arbiter.sv
// Shares the accumulator file's single write port between the ALU and load paths.
// It uses round-robin on contention, a registered write stage, address filtering and a contention counter.
//
// last_win | meaning
// ---------+-----------------------------------------------------------
// WIN_ALU  | ALU won the last contended cycle; the load path wins the next one
// WIN_LD   | Load path won the last contended cycle (reset); the ALU wins the next one
module acc_write_arbiter #(
    parameter int NUM_ACC = 6,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                freeze,
    acc_write_arbiter_if.slave  bus,
    output logic [7:0]          conflict_cnt
);
    typedef enum logic {
        WIN_ALU = 1'b0,
        WIN_LD  = 1'b1
    } win_t;

    win_t              last_win;
    win_t              last_win_nxt;
    logic              active;
    logic              contend;
    logic              grant_alu;
    logic              grant_ld;
    logic              xfer;
    logic              in_range;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            last_win <= WIN_LD;
        end else begin
            last_win <= last_win_nxt;
        end
    end

    always_comb begin
        last_win_nxt = last_win;
        grant_alu    = 1'b0;
        grant_ld     = 1'b0;
        active       = RST_N && !freeze;
        contend      = active && bus.alu_valid && bus.ld_valid;
        if (contend) begin
            if (last_win == WIN_LD) begin
                grant_alu    = 1'b1;
                last_win_nxt = WIN_ALU;
            end else begin
                grant_ld     = 1'b1;
                last_win_nxt = WIN_LD;
            end
        end else if (active) begin
            grant_alu = bus.alu_valid;
            grant_ld  = bus.ld_valid;
        end
    end

    assign bus.alu_ready = grant_alu;
    assign bus.ld_ready  = grant_ld;

    always_comb begin
        sel_reg  = grant_ld ? bus.ld_reg  : bus.alu_reg;
        sel_data = grant_ld ? bus.ld_data : bus.alu_data;
        xfer     = grant_alu || grant_ld;
        // Widen by one bit so NUM_ACC == 2**ADDR_W still compares correctly.
        in_range = {1'b0, sel_reg} < (ADDR_W+1)'(NUM_ACC);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bus.isWrite   <= 1'b0;
            bus.writeReg  <= '0;
            bus.writeData <= '0;
            bus.bad_addr  <= 1'b0;
            conflict_cnt  <= 8'd0;
        end else begin
            bus.isWrite  <= xfer && in_range;
            bus.bad_addr <= xfer && !in_range;
            if (xfer && in_range) begin
                bus.writeReg  <= sel_reg;
                bus.writeData <= sel_data;
            end
            if (contend && (conflict_cnt != 8'hFF)) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end
endmodule

// File: doc/acc_write_arbiter.md
# acc_write_arbiter

Write-port arbiter and sequencer for the 6-entry, 8-bit accumulator register file. It shares the file's single write port (isWrite/writeReg/writeData) between two requesters: the ALU result path and the load path. Each requester has a valid/ready handshake. Accepted writes are registered and presented to the accumulator file one cycle later. The block also filters out-of-range addresses and counts contended cycles for debug.

## Interface
Parameters:
- NUM_ACC, 6, number of implemented accumulators; addresses >= NUM_ACC are invalid
- ADDR_W, 3, accumulator address width
- DATA_W, 8, accumulator data width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, synchronous, active-low
- freeze  in  1  global stall; while high no request is granted
- alu_valid  in  1  ALU write request
- alu_reg  in  ADDR_W  ALU target accumulator
- alu_data  in  DATA_W  ALU write data
- alu_ready  out  1  ALU request accepted this cycle (combinational)
- ld_valid  in  1  load write request
- ld_reg  in  ADDR_W  load target accumulator
- ld_data  in  DATA_W  load write data
- ld_ready  out  1  load request accepted this cycle (combinational)
- isWrite  out  1  write enable to the accumulator file (registered)
- writeReg  out  ADDR_W  write address to the accumulator file (registered)
- writeData  out  DATA_W  write data to the accumulator file (registered)
- bad_addr  out  1  one-cycle pulse: an accepted request targeted an address >= NUM_ACC
- conflict_cnt  out  8  saturating count of cycles where both requesters were valid and not frozen

## Operation
- Handshake: a transfer occurs when valid && ready. A requester holds valid, reg and data stable until ready. Ready is never high while its own valid is low.
- Grant (combinational, per cycle):
  - freeze=1 or RST_N=0: both readies 0.
  - Only one valid: that requester's ready=1.
  - Both valid: grant the requester that did not win the last contended cycle. This is tracked by the 1-bit register last_win (0=ALU, 1=LD).
- last_win updates only on contended grants. Single-requester grants do not change it.
- Registered output stage, loaded every cycle:
  - Transfer with reg < NUM_ACC: isWrite=1, writeReg/writeData = granted reg/data, bad_addr=0.
  - Transfer with reg >= NUM_ACC: request is consumed. isWrite=0, bad_addr=1, writeReg/writeData hold their previous values.
  - No transfer: isWrite=0, bad_addr=0, writeReg/writeData hold.
- The downstream file always accepts writes, so the output stage never back-pressures.
- conflict_cnt increments by 1 on any cycle with alu_valid && ld_valid && !freeze && RST_N. It saturates at 255.
- Ordering: writes reach the file in grant order. Same-address writes in consecutive grants both occur in order, and the last one wins.

## Timing
- Reset (RST_N low at a rising edge): isWrite=0, writeReg=0, writeData=0, bad_addr=0, conflict_cnt=0, last_win=1 (so the ALU wins the first contended cycle).
- Reset mid-operation: a request presented while RST_N is low is not accepted (ready=0). Any write registered in the previous cycle has already been presented and is not cancelled retroactively.
- Latency: transfer in cycle N; isWrite/writeReg/writeData valid during cycle N+1; the accumulator file captures the data at the edge ending N+1. bad_addr also pulses in cycle N+1.
- Throughput: one write per cycle. Under continuous contention, grants alternate ALU, LD, ALU, … with no idle cycles.
- freeze asserted in cycle N blocks grants in N only. It does not clear the output stage; a write accepted in N-1 still appears in N.
- The next output stage loads one cycle after freeze deasserts.
- Simultaneous same-address requests: serialized by round-robin. The loser's data is written one cycle after the winner's, so the loser's value persists.

## Test plan
- Reset then single ALU request (reg=2, data=0x5A) -> alu_ready=1 same cycle; next cycle isWrite=1, writeReg=2, writeData=0x5A; following idle cycle isWrite=0.
- Both valid continuously for 4 cycles (ALU reg=1 data=0x11, LD reg=3 data=0x33), each deasserting after acceptance and re-asserting -> grant order ALU, LD, ALU, LD; conflict_cnt=4.
- LD request to reg=6, then reg=7 -> ld_ready=1 each cycle; isWrite=0 and bad_addr=1 in the cycle following each; writeReg/writeData unchanged.
- Both valid with freeze=1 for 3 cycles, then freeze=0 -> no readies and isWrite=0 while frozen; conflict_cnt unchanged; the ALU is granted first after release.
- RST_N low for 1 cycle while both requesters are valid and a write is in the output stage -> that write still appears in the reset cycle; after the edge all outputs are 0; neither ready is high during reset; the first contended grant after reset goes to the ALU.
- 300 consecutive contended cycles -> conflict_cnt saturates at 255 and holds.
